single_for_src: RTL and testbench
=================================

// Module: single_for_src
// PURPOSE
//  Source/driver for the single_for burst accumulator.
//  - Buffers up to 16 bytes written by a host.
//  - On start, issues one add_en pulse and the matching num, then streams the bytes on data.
//  - Waits for add_end and captures sum into result.
//  - Sits between host logic and the accumulator, driving the accumulator's input side.
// PARAMETERS
//  DW       8   data/sum width; must equal accumulator width
//  DEPTH    16  buffer depth; fixed by the 4-bit num field; not user-tunable
//  TIMEOUT  8   max cycles spent in WAIT before aborting
// PORTS
//  sys_clk  in   1      clock; all logic on rising edge
//  sys_rst  in   1      synchronous reset, active-high
//  wr_en    in   1      host write strobe
//  wr_data  in   DW     host byte
//  wr_ready out  1      write accepted this cycle if wr_en=1
//  start    in   1      launch burst of all buffered bytes
//  busy     out  1      burst in progress
//  done     out  1      one-cycle pulse, burst finished
//  err      out  1      valid with done; burst failed
//  result   out  DW     sum captured from accumulator
//  add_en   out  1      to accumulator: one-cycle start pulse
//  num      out  4      to accumulator: byte count minus 1; held for whole burst
//  data     out  DW     to accumulator: streamed byte
//  add_end  in   1      from accumulator: sum valid this cycle
//  sum      in   DW     from accumulator
// BEHAVIOUR
//  Reset: every output is 0 (wr_ready is 1 one cycle after reset). Buffer count=0, state IDLE.
//  FSM states: IDLE -> KICK -> STREAM -> WAIT -> DONE -> IDLE.
//  IDLE
//   - wr_ready = (count<16) && !start.
//   - An accepted write stores to buf[count]; count++.
//   - start has priority over wr_en in the same cycle; that write is dropped with wr_ready=0.
//   - start with count=0 is ignored: no add_en, busy stays 0.
//   - start with count>0: next cycle is KICK.
//  KICK (1 cycle)
//   - add_en=1, num=count-1, busy=1, data=0.
//  STREAM (count cycles)
//   - data=buf[i] for i=0..count-1, on consecutive cycles.
//   - Byte 0 appears the cycle immediately after the add_en cycle.
//   - This matches the accumulator adding num+1 words, one per cycle, starting one cycle after add_en.
//  WAIT
//   - data=0; sample add_end on each edge.
//   - add_end=1: result<=sum; go to DONE.
//   - TIMEOUT cycles without add_end: err<=1, result unchanged; go to DONE.
//   - Nominal: add_end arrives in the first WAIT cycle, i.e. KICK + count + 1.
//  DONE (1 cycle)
//   - done=1; count cleared; busy=0 from the next cycle.
//  Timing, other rules
//   - add_en, num, data, done, busy, err are registered.
//   - num holds its value from KICK through DONE; it is 0 otherwise.
//   - add_end outside WAIT is ignored.
//   - wr_en and start are ignored while busy (wr_ready=0).
//   - Sums are modulo 2^DW: wrap is not an error.
//   - err clears at the next accepted start.
//   - sys_rst asserted in any state returns to IDLE the next cycle.
//     add_en, data and num go to 0 immediately; the buffer is emptied; no done pulse.
// CONFIGURATION
//  SINGLE_FOR_SRC_CHECK_EN
//   - Defined: a DW-bit expected sum (mod 2^DW) accumulates during STREAM.
//     On add_end, err=1 if sum != expected; result still takes sum.
//   - Undefined: no checker logic; err is set only by timeout.
// TESTING
//  1. Write 10,20,30; start -> add_en pulse, num=2, data 10,20,30 next 3 cycles;
//     stub add_end, sum=60 -> result=60, done 1 cycle, err=0.
//  2. Write 16x 0x20; start -> num=15, 16 data cycles;
//     stub sum=0x00 -> result=0x00, err=0 (wrap legal).
//  3. start with empty buffer -> no add_en, busy=0, done=0 for 20 cycles.
//  4. 17th write -> wr_ready=0, count stays 16.
//     start+wr_en same cycle -> write dropped, num=15.
//  5. Stub never raises add_end -> TIMEOUT=8 cycles after WAIT entry, done=1, err=1, result unchanged.
//  6. CHECK_EN on, bytes 1,2,3, stub sum=7 -> err=1, result=7.
//     Then reset mid-STREAM -> next cycle add_en=0, data=0, busy=0, wr_ready=1.

Source files
------------

// File: rtl/single_for_src.sv
// rtl/single_for_src.sv - host byte buffer that drives one burst into the single_for accumulator
// Optional checker: define SINGLE_FOR_SRC_CHECK_EN to compare the returned sum against the streamed bytes.
module single_for_src #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result,
    output logic          add_en,
    output logic [3:0]    num,
    output logic [DW-1:0] data,
    input  logic          add_end,
    input  logic [DW-1:0] sum
);
    localparam int DEPTH = 16;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_KICK, S_STREAM, S_WAIT, S_DONE} state_t;

    state_t          state_q;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [4:0]      count_q;
    logic [4:0]      idx_q;
    logic [TW-1:0]   tmo_q;
    logic            add_en_q, busy_q, done_q, err_q;
    logic [3:0]      num_q;
    logic [DW-1:0]   data_q, result_q;
    logic            wr_accept;
`ifdef SINGLE_FOR_SRC_CHECK_EN
    logic [DW-1:0]   exp_q;
`endif

    // start wins over a same-cycle write, so the write is refused here
    assign wr_ready  = (state_q == S_IDLE) && (count_q < 5'(DEPTH)) && !start;
    assign wr_accept = wr_en && wr_ready;

    always_ff @(posedge sys_clk) begin
        if (wr_accept) mem_q[count_q[3:0]] <= wr_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            add_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            num_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
`ifdef SINGLE_FOR_SRC_CHECK_EN
            exp_q    <= '0;
`endif
        end else begin
            add_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && count_q != 5'd0) begin
                        state_q  <= S_KICK;
                        add_en_q <= 1'b1;
                        num_q    <= 4'(count_q - 5'd1);
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
`ifdef SINGLE_FOR_SRC_CHECK_EN
                        exp_q    <= '0;
`endif
                    end else if (wr_accept) begin
                        count_q <= count_q + 5'd1;
                    end
                end
                S_KICK: begin
                    state_q <= S_STREAM;
                    data_q  <= mem_q[0];
                    idx_q   <= 5'd1;
`ifdef SINGLE_FOR_SRC_CHECK_EN
                    exp_q   <= exp_q + mem_q[0];
`endif
                end
                S_STREAM: begin
                    if (idx_q == count_q) begin
                        state_q <= S_WAIT;
                        data_q  <= '0;
                        tmo_q   <= '0;
                    end else begin
                        data_q  <= mem_q[idx_q[3:0]];
                        idx_q   <= idx_q + 5'd1;
`ifdef SINGLE_FOR_SRC_CHECK_EN
                        exp_q   <= exp_q + mem_q[idx_q[3:0]];
`endif
                    end
                end
                S_WAIT: begin
                    if (add_end) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= sum;
`ifdef SINGLE_FOR_SRC_CHECK_EN
                        err_q    <= (sum != exp_q);
`endif
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    num_q   <= '0;
                    count_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign add_en = add_en_q;
    assign num    = num_q;
    assign data   = data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
endmodule

// File: tb/tb_single_for_src.sv
// tb/tb_single_for_src.sv - randomized bench for single_for_src with a queue-based reference and accumulator stub
module tb_single_for_src;
    logic       sys_clk = 1'b0;
    logic       sys_rst, wr_en, start, add_end;
    logic [7:0] wr_data, sum;
    logic       wr_ready, busy, done, err, add_en;
    logic [7:0] result, data;
    logic [3:0] num;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];
    logic [7:0] exp_result = 8'h00;
    logic       exp_err    = 1'b0;
`ifdef SINGLE_FOR_SRC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    single_for_src dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start), .busy(busy), .done(done), .err(err),
        .result(result), .add_en(add_en), .num(num), .data(data),
        .add_end(add_end), .sum(sum)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bit room;
        room    = (q.size() < 16);
        wr_en   = 1'b1;
        wr_data = b;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(room));
        if (room) q.push_back(b);
        step();
        wr_en = 1'b0;
    endtask

    // mode: 0 nominal, 1 late add_end, 2 no add_end, 3 wrong sum
    task automatic run_burst(input int mode, input int dly, input bit glitch, input bit wr_with_start);
        int         n;
        int         es;
        logic [7:0] s;
        n  = q.size();
        es = 0;
        foreach (q[i]) es += int'(q[i]);
        start   = 1'b1;
        wr_en   = wr_with_start;
        wr_data = 8'hEE;
        #1;
        chk("wr_ready_at_start", 32'(wr_ready), 0);
        step();
        start = 1'b0;
        wr_en = 1'b0;
        if (glitch) begin
            add_end = 1'b1;
            sum     = 8'($urandom);
        end
        chk("kick_add_en", 32'(add_en), 1);
        chk("kick_num", 32'(num), 32'(n - 1));
        chk("kick_busy", 32'(busy), 1);
        chk("kick_data", 32'(data), 0);
        chk("kick_err", 32'(err), 0);
        for (int i = 0; i < n; i++) begin
            step();
            add_end = 1'b0;
            chk("stream_data", 32'(data), 32'(q[i]));
            chk("stream_add_en", 32'(add_en), 0);
            chk("stream_num", 32'(num), 32'(n - 1));
        end
        step();
        chk("wait_data", 32'(data), 0);
        chk("wait_busy", 32'(busy), 1);
        if (mode == 2) begin
            for (int k = 0; k < 8; k++) begin
                chk("wait_no_done", 32'(done), 0);
                step();
            end
            exp_err = 1'b1;
        end else begin
            s = (mode == 3) ? 8'(es + 1) : 8'(es);
            for (int k = 0; k < ((mode == 1) ? dly : 0); k++) begin
                chk("late_no_done", 32'(done), 0);
                step();
            end
            add_end = 1'b1;
            sum     = s;
            step();
            add_end    = 1'b0;
            exp_result = s;
            exp_err    = (mode == 3) && CHECK_EN;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_result", 32'(result), 32'(exp_result));
        chk("done_busy", 32'(busy), 1);
        chk("done_num", 32'(num), 32'(n - 1));
        step();
        chk("after_done", 32'(done), 0);
        chk("after_busy", 32'(busy), 0);
        chk("after_num", 32'(num), 0);
        chk("after_err", 32'(err), 32'(exp_err));
        chk("after_result", 32'(result), 32'(exp_result));
        #1;
        chk("after_wr_ready", 32'(wr_ready), 1);
        q.delete();
    endtask

    initial begin
        sys_rst = 1'b1; wr_en = 1'b0; start = 1'b0; add_end = 1'b0;
        wr_data = 8'h00; sum = 8'h00;
        step();
        step();
        chk("rst_add_en", 32'(add_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_num", 32'(num), 0);
        chk("rst_data", 32'(data), 0);
        sys_rst = 1'b0;
        step();
        chk("post_rst_wr_ready", 32'(wr_ready), 1);

        write_byte(8'd10); write_byte(8'd20); write_byte(8'd30);
        run_burst(0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) write_byte(8'h20);
        run_burst(0, 0, 1'b0, 1'b0);

        start = 1'b1;
        #1;
        chk("empty_wr_ready", 32'(wr_ready), 0);
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("empty_add_en", 32'(add_en), 0);
            chk("empty_busy", 32'(busy), 0);
            chk("empty_done", 32'(done), 0);
            step();
        end

        for (int i = 0; i < 17; i++) write_byte(8'(i * 3 + 1));
        run_burst(0, 0, 1'b0, 1'b1);

        write_byte(8'h11); write_byte(8'h22);
        run_burst(2, 0, 1'b0, 1'b0);

        write_byte(8'd1); write_byte(8'd2); write_byte(8'd3);
        run_burst(3, 0, 1'b0, 1'b0);

        write_byte(8'd1); write_byte(8'd2); write_byte(8'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("rst_mid_add_en", 32'(add_en), 0);
        chk("rst_mid_data", 32'(data), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_num", 32'(num), 0);
        chk("rst_mid_done", 32'(done), 0);
        #1;
        chk("rst_mid_wr_ready", 32'(wr_ready), 1);
        q.delete();
        exp_result = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_emptied_add_en", 32'(add_en), 0);
        chk("rst_emptied_busy", 32'(busy), 0);

        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(1, 17));
            for (int i = 0; i < n; i++) write_byte(8'($urandom));
            run_burst(int'($urandom_range(0, 3)), int'($urandom_range(1, 7)),
                      1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
